simon_datapath: RTL and testbench

Datapath partner to the Simon control FSM: stores the growing pattern sequence, walks it during playback, checks the player's repeat attempts, and cycles the stored sequence on game-over. It consumes the controller's `select`, `w_en` and `clrcount` and returns the four status flags the controller branches on, plus the 4-bit pattern LED drive.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/simon_pattern_mem.sv | 26 ++
 rtl/simon_datapath.sv | 90 +++++++++
 tb/tb_simon_datapath.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - select encodings, pattern width and mode decode shared with the Simon controller
package simon_pkg;

  localparam int PW = 4;

  localparam logic [1:0] SEL_PLAYBACK = 2'b00;
  localparam logic [1:0] SEL_REPEAT   = 2'b01;
  localparam logic [1:0] SEL_DONE     = 2'b10;

  typedef enum logic [1:0] {
    MODE_INPUT,
    MODE_PLAYBACK,
    MODE_REPEAT,
    MODE_DONE
  } mode_t;

  // w_en wins because select is stale while the controller sits in INPUT
  function automatic mode_t decode_mode(input logic w_en, input logic [1:0] select);
    if (w_en)                      return MODE_INPUT;
    else if (select == SEL_PLAYBACK) return MODE_PLAYBACK;
    else if (select == SEL_REPEAT)   return MODE_REPEAT;
    else                           return MODE_DONE;
  endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// rtl/simon_pattern_mem.sv - sequence storage, one synchronous write port and two asynchronous read ports
module simon_pattern_mem #(
  parameter int DEPTH = 64,
  parameter int PW    = 4,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [IW-1:0] raddr_a,
  output logic [PW-1:0] rdata_a,
  input  logic [IW-1:0] raddr_b,
  output logic [PW-1:0] rdata_b
);

  logic [PW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/simon_datapath.sv
// rtl/simon_datapath.sv - Simon sequence store, playback/repeat/done index walkers, status flags and LED mux
module simon_datapath #(
  parameter int DEPTH = 64,
  parameter int PW    = simon_pkg::PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          level,
  input  logic [PW-1:0] pattern,
  input  logic [1:0]    select,
  input  logic          w_en,
  input  logic          clrcount,
  output logic          is_legal,
  output logic          play_gt_count,
  output logic          repeat_eq_play,
  output logic          input_eq_pattern,
  output logic [PW-1:0] pattern_leds
);
  import simon_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  mode_t         mode;
  logic [CW-1:0] count;
  logic [IW-1:0] play_idx, rep_idx, done_idx;
  logic [IW-1:0] last_idx, rd_a_idx;
  logic [PW-1:0] rd_a, rd_rep;
  logic          one_hot, mem_we;

  assign mode     = decode_mode(w_en, select);
  assign last_idx = count[IW-1:0] - IW'(1);
  assign one_hot  = (pattern != '0) && ((pattern & (pattern - PW'(1))) == '0);

  assign is_legal         = (count < CW'(DEPTH)) && (!level || one_hot);
  assign play_gt_count    = (play_idx == last_idx);
  assign repeat_eq_play   = (rep_idx == last_idx);
  assign input_eq_pattern = (pattern == rd_rep);

  // Reset has to block the write too, not just the count update
  assign mem_we   = (mode == MODE_INPUT) && is_legal && !rst && !clrcount;
  assign rd_a_idx = (mode == MODE_PLAYBACK) ? play_idx : done_idx;

  simon_pattern_mem #(.DEPTH(DEPTH), .PW(PW)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (count[IW-1:0]),
    .wdata   (pattern),
    .raddr_a (rd_a_idx),
    .rdata_a (rd_a),
    .raddr_b (rep_idx),
    .rdata_b (rd_rep)
  );

  always_comb begin
    pattern_leds = pattern;
    if (mode == MODE_PLAYBACK || mode == MODE_DONE) pattern_leds = rd_a;
  end

  always_ff @(posedge clk) begin
    if (rst || clrcount) begin
      count    <= '0;
      play_idx <= '0;
      rep_idx  <= '0;
      done_idx <= '0;
    end else begin
      if (mode != MODE_DONE) done_idx <= '0;
      case (mode)
        MODE_INPUT: begin
          if (is_legal) begin
            count    <= count + CW'(1);
            play_idx <= '0;
          end
        end
        MODE_PLAYBACK: begin
          if (!play_gt_count) play_idx <= play_idx + IW'(1);
          rep_idx <= '0;
        end
        MODE_REPEAT: begin
          // a mismatch leaves rep_idx on the failing entry
          if (input_eq_pattern) rep_idx <= repeat_eq_play ? '0 : rep_idx + IW'(1);
        end
        default: begin
          done_idx <= (done_idx == last_idx) ? '0 : done_idx + IW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_datapath.sv
// tb/tb_simon_datapath.sv - randomized and directed checks of simon_datapath against a game-level reference model
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       rst, level, w_en, clrcount;
  logic [3:0] pattern;
  logic [1:0] select;
  logic       is_legal, play_gt_count, repeat_eq_play, input_eq_pattern;
  logic [3:0] pattern_leds;

  int checks = 0;
  int failures = 0;

  int         m_count, m_play, m_rep, m_done;
  logic [3:0] m_mem [64];
  bit         m_valid [64];

  simon_datapath #(.DEPTH(64), .PW(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .level            (level),
    .pattern          (pattern),
    .select           (select),
    .w_en             (w_en),
    .clrcount         (clrcount),
    .is_legal         (is_legal),
    .play_gt_count    (play_gt_count),
    .repeat_eq_play   (repeat_eq_play),
    .input_eq_pattern (input_eq_pattern),
    .pattern_leds     (pattern_leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model on the rising edge
  task automatic step();
    int  md, last;
    bit  legal;
    @(negedge clk);
    md    = w_en ? 0 : (select == 2'b00 ? 1 : (select == 2'b01 ? 2 : 3));
    last  = (m_count + 63) % 64;
    legal = (m_count < 64) && (!level || $countones(pattern) == 1);
    check("is_legal", is_legal, legal);
    check("play_gt_count", play_gt_count, m_play == last);
    check("repeat_eq_play", repeat_eq_play, m_rep == last);
    if (m_valid[m_rep]) check("input_eq_pattern", input_eq_pattern, pattern == m_mem[m_rep]);
    if (md == 0 || md == 2)            check("leds_live", pattern_leds, pattern);
    else if (md == 1 && m_valid[m_play]) check("leds_play", pattern_leds, m_mem[m_play]);
    else if (md == 3 && m_valid[m_done]) check("leds_done", pattern_leds, m_mem[m_done]);
    @(posedge clk);
    if (rst || clrcount) begin
      m_count = 0; m_play = 0; m_rep = 0; m_done = 0;
    end else begin
      if (md != 3) m_done = 0;
      case (md)
        0: if (legal) begin
             m_mem[m_count] = pattern; m_valid[m_count] = 1'b1;
             m_count++; m_play = 0;
           end
        1: begin
             if (m_play != last) m_play++;
             m_rep = 0;
           end
        2: if (pattern == m_mem[m_rep]) m_rep = (m_rep == last) ? 0 : m_rep + 1;
        default: m_done = (m_done == last) ? 0 : m_done + 1;
      endcase
    end
    #1;
  endtask

  task automatic drive(input bit we, input logic [1:0] sel, input logic [3:0] pat);
    w_en = we; select = sel; pattern = pat;
  endtask

  initial begin
    logic [3:0] seq [3];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    m_count = 0; m_play = 0; m_rep = 0; m_done = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    rst = 1'b1; clrcount = 1'b0; level = 1'b0;
    drive(1'b1, 2'b00, 4'b0011);
    @(posedge clk); #1;
    step();
    rst = 1'b0;

    drive(1'b1, 2'b00, 4'b1011); #1;
    check("reset_legal", is_legal, 1'b1);
    check("reset_leds", pattern_leds, 4'b1011);

    // Legality with no writes (DONE mode)
    level = 1'b1; drive(1'b0, 2'b10, 4'b0101); #1;
    check("hard_0101", is_legal, 1'b0);
    step();
    drive(1'b0, 2'b10, 4'b0100); #1;
    check("hard_0100", is_legal, 1'b1);
    step();
    level = 1'b0; drive(1'b0, 2'b10, 4'b0000); #1;
    check("easy_0000", is_legal, 1'b1);
    step();

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, seq[k]);
      step();
      drive(1'b0, 2'b00, 4'b1111);
      for (int c = 0; c <= k; c++) begin
        #1;
        if (k == 2) begin
          check("pb3_leds", pattern_leds, seq[c]);
          check("pb3_last", play_gt_count, c == 2);
        end
        step();
      end
    end

    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'b01, seq[c]); #1;
      check("rep_match", input_eq_pattern, 1'b1);
      check("rep_last", repeat_eq_play, c == 2);
      step();
    end
    drive(1'b0, 2'b01, 4'b0001); #1;
    check("rep_wrapped", input_eq_pattern, 1'b1);
    step();
    drive(1'b0, 2'b01, 4'b1000); #1;
    check("rep_miss", input_eq_pattern, 1'b0);
    step();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 2'b10, 4'b0000); #1;
      check("done_leds", pattern_leds, seq[c % 3]);
      step();
    end

    // clrcount mid-REPEAT
    drive(1'b0, 2'b01, 4'b0001); step();
    clrcount = 1'b1; drive(1'b0, 2'b01, 4'b0010); step();
    clrcount = 1'b0;
    drive(1'b1, 2'b00, 4'b1010); step();
    drive(1'b0, 2'b00, 4'b0000); #1;
    check("clr_pb_leds", pattern_leds, 4'b1010);
    check("clr_pb_last", play_gt_count, 1'b1);
    step();

    // rst beats a legal write; fill afterwards must take exactly 64 writes
    rst = 1'b1; drive(1'b1, 2'b00, 4'b0011); step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 2'b00, 4'($urandom));
      step();
    end
    level = 1'b0; drive(1'b1, 2'b00, 4'b0110); #1;
    check("full_easy", is_legal, 1'b0);
    step();
    level = 1'b1; drive(1'b1, 2'b00, 4'b0010); #1;
    check("full_hard", is_legal, 1'b0);
    step();
    level = 1'b0; drive(1'b0, 2'b00, 4'b0000);
    for (int c = 0; c < 64; c++) step();
    #1;
    check("full_pb_end", play_gt_count, 1'b1);
    check("full_pb_leds", pattern_leds, m_mem[63]);
    step();

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      rst      = (r < 1);
      clrcount = (r >= 1 && r < 3);
      level    = 1'($urandom);
      w_en     = (m_count == 0) || ($urandom_range(0, 99) < 30);
      select   = 2'($urandom);
      if (!w_en && select == 2'b01 && $urandom_range(0, 3) != 0) pattern = m_mem[m_rep];
      else if (level && $urandom_range(0, 1) == 1)              pattern = 4'(1 << $urandom_range(0, 3));
      else                                                         pattern = 4'($urandom);
      step();
    end
    rst = 1'b0; clrcount = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
